// File: rtl/upcounter.sv
// Free-running binary up-counter with synchronous active-high reset.
// Advances by STEP per rising edge and wraps to zero past MAX_VALUE.
module upcounter #(
    parameter int unsigned      WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] MAX_VALUE   = '1,
    parameter logic [WIDTH-1:0] STEP        = WIDTH'(1)
) (
    input  logic             clock,
    output logic [WIDTH-1:0] count,
    input  logic             reset
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH:0]   sum;

    // One extra bit so a sum past 2^WIDTH-1 is seen before truncation.
    assign sum = {1'b0, count_q} + {1'b0, STEP};

    always_comb begin
        count_d = sum[WIDTH-1:0];
        if ((count_q >= MAX_VALUE) || (sum > {1'b0, MAX_VALUE})) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= RESET_VALUE;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_upcounter.sv
// Scoreboard bench for upcounter: four parameter variants share one clock and reset,
// expected counts are queued at stimulus time and popped by a monitor after each edge.
module tb_upcounter;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] c_def;
    logic [3:0] c_dec;
    logic [3:0] c_st3;
    logic [2:0] c_odd;

    always #5 clock = ~clock;

    upcounter u_def (
        .clock (clock),
        .count (c_def),
        .reset (reset)
    );

    upcounter #(
        .WIDTH     (4),
        .MAX_VALUE (4'd9)
    ) u_dec (
        .clock (clock),
        .count (c_dec),
        .reset (reset)
    );

    upcounter #(
        .WIDTH (4),
        .STEP  (4'd3)
    ) u_st3 (
        .clock (clock),
        .count (c_st3),
        .reset (reset)
    );

    upcounter #(
        .WIDTH       (3),
        .RESET_VALUE (3'd2),
        .MAX_VALUE   (3'd6),
        .STEP        (3'd2)
    ) u_odd (
        .clock (clock),
        .count (c_odd),
        .reset (reset)
    );

    typedef struct {
        int v0;
        int v1;
        int v2;
        int v3;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   m[4];
    int   step_p[4] = '{1, 1, 3, 2};
    int   max_p[4]  = '{15, 9, 15, 6};
    int   rv_p[4]   = '{0, 0, 0, 2};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Drive reset for the next edge; an optional glitch pulses reset high and low
    // entirely between edges, which must leave the count untouched.
    task automatic step(input bit r, input bit glitch);
        exp_t e;
        @(negedge clock);
        if (glitch && !r) begin
            reset = 1'b1;
            #2;
        end
        reset = r;
        for (int i = 0; i < 4; i++) begin
            if (r) m[i] = rv_p[i];
            else if (m[i] + step_p[i] > max_p[i]) m[i] = 0;
            else m[i] = m[i] + step_p[i];
        end
        e.v0 = m[0];
        e.v1 = m[1];
        e.v2 = m[2];
        e.v3 = m[3];
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("default", int'(c_def), e.v0);
                chk("decade", int'(c_dec), e.v1);
                chk("step3", int'(c_st3), e.v2);
                chk("odd_rv2_step2", int'(c_odd), e.v3);
            end
        end
    end

    initial begin : stimulus
        int k;
        reset = 1'b1;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        repeat (40) step(1'b0, 1'b0);
        k = 0;
        while (m[0] != 9 && k < 20) begin
            step(1'b0, 1'b0);
            k++;
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        repeat (20) step(1'b0, 1'b1);
        repeat (300) step($urandom_range(15) == 0, $urandom_range(3) == 0);
        @(negedge clock);
        @(negedge clock);
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/upcounter.md
Name: upcounter

Overview:
- Free-running synchronous binary up-counter, 4 bits by default, with synchronous active-high reset.
- Used as a basic timing/sequence source: the count advances by one on every rising clock edge and wraps modulo 2^WIDTH (or a programmed terminal value).
- Single clock domain, no handshake; the output is fully registered.

Parameters:
- WIDTH, 4, bit width of count; legal range 1..32.
- RESET_VALUE, 0, value loaded into count on reset; must fit in WIDTH bits.
- MAX_VALUE, 2^WIDTH-1, terminal value; the count after MAX_VALUE is 0. Legal range RESET_VALUE..2^WIDTH-1.
- STEP, 1, increment applied per clock; legal range 1..2^WIDTH-1.

Ports:
- Port order is fixed as listed, because existing benches connect by position.
- clock  input  1  rising-edge clock; the only clock.
- count  output  WIDTH  current counter value, driven directly from a register.
- reset  input  1  synchronous, active-high reset; sampled only on the rising edge of clock.

Behaviour:
- One clock; reset is synchronous and active-high.
- All state changes occur on the rising edge of clock. No asynchronous paths; count has no combinational dependence on inputs.
- Reset: if reset=1 at a rising edge, count <= RESET_VALUE (0 by default) on that edge.
  - Reset has priority over counting.
  - Reset held for N edges keeps count at RESET_VALUE for all N edges.
- Count: if reset=0 at a rising edge:
  - if count >= MAX_VALUE, or count + STEP > MAX_VALUE, then count <= 0;
  - otherwise count <= count + STEP.
  - Arithmetic is done in WIDTH+1 bits so overflow is detected before truncation.
- Default configuration (WIDTH=4, STEP=1, MAX=15):
  - sequence after reset release is 0,1,2,...,15,0,1,...
  - one increment per edge; 15 -> 0 wraps with no extra cycle.
- Latency: the first edge with reset=0 after reset produces count=RESET_VALUE+STEP (1 by default). There is no dead cycle.
- Reset mid-operation: at any count value, asserting reset forces RESET_VALUE on the next edge. Counting resumes from that value on the first edge with reset low.
- Power-up: count is unspecified (X in simulation) until the first edge with reset=1. No initial-value reliance.
- If reset is X/Z at an edge, simulation models may propagate X. Synthesis behaviour is unconstrained.
- No enable, load or terminal-count output in this block. Consumers decode count themselves.

Test Plan:
- Clock period 10, clock starts 0; hold reset=1 for 2 rising edges -> count=0 after the first reset edge and stays 0.
- Release reset (reset=0 before edge 3) -> count = 1,2,3,... on successive edges. After 15 edges from release count=15; the 16th edge gives count=0 (wrap).
- Run 40 edges continuously after reset -> sequence repeats period 16 with no skipped or duplicated values.
- Assert reset for one edge while count=9 -> count=0 on that edge. The next edge with reset=0 gives count=1.
- Change reset between clock edges (pulse high and low mid-period without spanning an edge) -> count unaffected, proving synchronous reset.
- Parameter variant WIDTH=4, MAX_VALUE=9, RESET_VALUE=0 -> sequence 0..9,0 (decade). Variant STEP=3, WIDTH=4 -> 0,3,6,9,12,15,0.
